// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receiver control block:
// config FSM states, legal prescale values and idle-frame detection helpers.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } cfg_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int IDLE_BITS  = 10;
  localparam int IDLE_CNT_W = 10;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // Last counter value of a full idle frame; 10 x 32 - 1 still fits in 10 bits.
  function automatic logic [IDLE_CNT_W-1:0] idle_threshold(input logic [5:0] p);
    return IDLE_CNT_W'(p) * IDLE_CNT_W'(IDLE_BITS) - IDLE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Show-ahead synchronous byte FIFO used to buffer received UART bytes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              pop_en;

  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign pop_en = pop && !empty;
  assign wr_en  = push && (!full || pop_en);
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: deferred configuration (applied after a full idle frame)
// and received-byte buffering. Optional drop counter: UART_RX_CTRL_DROP_CNT_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int         FIFO_DEPTH       = 8,
  parameter logic [5:0] DEFAULT_PRESCALE = 6'd8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          cfg_wr,
  input  logic [5:0]                    cfg_prescale,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_typ,
  output logic                          cfg_busy,
  output logic                          cfg_err,
  input  logic                          rx_in,
  output logic [5:0]                    prescale,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  input  logic [7:0]                    rx_p_data,
  input  logic                          rx_data_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic [7:0]                    drop_cnt
);

  cfg_state_e            state;
  cfg_state_e            state_nxt;
  logic                  wr_legal;
  logic                  idle_done;
  logic                  apply_en;
  logic [IDLE_CNT_W-1:0] idle_cnt;
  logic [5:0]            sh_prescale;
  logic                  sh_par_en;
  logic                  sh_par_typ;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  assign wr_legal  = cfg_wr && is_legal_prescale(cfg_prescale);
  assign idle_done = rx_in && (idle_cnt == idle_threshold(prescale));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_RUN;
    else      state <= state_nxt;
  end

  // A fresh legal write while pending restarts the idle wait, even on the last idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (wr_legal) state_nxt = S_PEND;
      S_PEND:  if (!wr_legal && idle_done) state_nxt = S_APPLY;
      S_APPLY: state_nxt = wr_legal ? S_PEND : S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    cfg_busy = (state != S_RUN);
    apply_en = (state == S_APPLY);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt    <= '0;
      sh_prescale <= DEFAULT_PRESCALE;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= 1'b0;
      prescale    <= DEFAULT_PRESCALE;
      PAR_EN      <= 1'b0;
      PAR_TYP     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !is_legal_prescale(cfg_prescale);
      if (wr_legal) begin
        sh_prescale <= cfg_prescale;
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
        idle_cnt    <= '0;
      end else if (state == S_PEND) begin
        idle_cnt <= rx_in ? idle_cnt + 1'b1 : '0;
      end
      // Shadow is read before any same-cycle capture, so a write in S_APPLY waits its turn.
      if (apply_en) begin
        prescale <= sh_prescale;
        PAR_EN   <= sh_par_en;
        PAR_TYP  <= sh_par_typ;
      end
    end
  end

  rx_byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (rx_data_valid),
    .pop   (out_ready),
    .wdata (rx_p_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = rx_data_valid && fifo_full && !pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         overrun <= 1'b0;
    else if (ovr_clr) overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
  end

`ifdef UART_RX_CTRL_DROP_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         drop_cnt <= '0;
    else if (ovr_clr) drop_cnt <= '0;
    else if (drop)    drop_cnt <= sat_inc(drop_cnt);
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue/counter reference model.
module tb_uart_rx_ctrl;

  localparam int FD = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [5:0] cfg_prescale = 6'd8;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_typ = 1'b0;
  logic       cfg_busy;
  logic       cfg_err;
  logic       rx_in = 1'b1;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] rx_p_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic [7:0] drop_cnt;

  uart_rx_ctrl #(.FIFO_DEPTH(FD), .DEFAULT_PRESCALE(6'd8)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .rx_in(rx_in), .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overrun(overrun), .ovr_clr(ovr_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [7:0] q[$];
  int m_p, m_en, m_typ, m_err, m_ovr, m_drop;
  int sh_p, sh_en, sh_typ;
  bit m_pend, m_apply;
  int m_run;

`ifdef UART_RX_CTRL_DROP_CNT_EN
  localparam bit DROP_ON = 1'b1;
`else
  localparam bit DROP_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_p = 8; m_en = 0; m_typ = 0; m_err = 0; m_ovr = 0; m_drop = 0;
    sh_p = 8; sh_en = 0; sh_typ = 0;
    m_pend = 0; m_apply = 0; m_run = 0;
  endtask

  // Config rule: apply once 10*prescale consecutive high line samples follow the
  // latest legal write; the outputs move one cycle after that.
  task automatic model_step();
    bit pop, full, drop, legal;
    pop  = (q.size() > 0) && out_ready;
    full = (q.size() == FD);
    drop = rx_data_valid && full && !pop;
    if (pop) void'(q.pop_front());
    if (rx_data_valid && !drop) q.push_back(rx_p_data);
    if (ovr_clr) begin m_ovr = 0; m_drop = 0; end
    else if (drop) begin m_ovr = 1; if (m_drop < 255) m_drop++; end

    legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
    m_err = (cfg_wr && !legal) ? 1 : 0;
    if (m_apply) begin
      m_p = sh_p; m_en = sh_en; m_typ = sh_typ;
      m_apply = 0; m_pend = 0;
    end else if (m_pend && !(cfg_wr && legal)) begin
      if (rx_in) begin
        m_run++;
        if (m_run == 10 * m_p) m_apply = 1;
      end else m_run = 0;
    end
    if (cfg_wr && legal) begin
      sh_p = int'(cfg_prescale); sh_en = int'(cfg_par_en); sh_typ = int'(cfg_par_typ);
      m_pend = 1; m_apply = 0; m_run = 0;
    end
  endtask

  task automatic check_outputs();
    chk("prescale", prescale, m_p);
    chk("par_en", PAR_EN, m_en);
    chk("par_typ", PAR_TYP, m_typ);
    chk("cfg_busy", cfg_busy, (m_pend || m_apply) ? 1 : 0);
    chk("cfg_err", cfg_err, m_err);
    chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
    chk("fifo_count", fifo_count, q.size());
    chk("overrun", overrun, m_ovr);
    chk("drop_cnt", drop_cnt, DROP_ON ? m_drop : 0);
    if (q.size() > 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    cfg_wr = 0; rx_data_valid = 0; out_ready = 0; ovr_clr = 0; rx_in = 1;
    RST = 1'b0;
    #2;
    chk("rst_prescale", prescale, 8);
    chk("rst_par_en", PAR_EN, 0);
    chk("rst_par_typ", PAR_TYP, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drop", drop_cnt, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic cfg_write(input logic [5:0] p, input logic en, input logic typ);
    cfg_wr = 1; cfg_prescale = p; cfg_par_en = en; cfg_par_typ = typ;
    tick();
    cfg_wr = 0;
  endtask

  initial begin
    int n;
    logic [7:0] last;
    logic [5:0] ptab [8];
    ptab[0] = 6'd8;  ptab[1] = 6'd16; ptab[2] = 6'd32; ptab[3] = 6'd12;
    ptab[4] = 6'd0;  ptab[5] = 6'd63; ptab[6] = 6'd24; ptab[7] = 6'd8;

    #1;
    do_reset();
    tick();

    // Deferred config: 10*8+1 cycles with the line idle
    cfg_write(6'd16, 1'b1, 1'b0);
    n = 0;
    while (prescale != 6'd16 && n < 300) begin tick(); n++; end
    chk("defer_latency", n, 81);
    chk("defer_par_en", PAR_EN, 1);
    chk("defer_busy_fall", cfg_busy, 0);

    // Idle restart: a low sample at cycle 40 restarts the 80-cycle idle wait
    do_reset();
    cfg_write(6'd16, 1'b1, 1'b1);
    n = 0;
    while (prescale != 6'd16 && n < 300) begin
      rx_in = (n + 1 == 40) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    rx_in = 1;
    chk("restart_latency", n, 121);
    chk("restart_par_typ", PAR_TYP, 1);

    // Reset while pending discards the shadow configuration
    cfg_write(6'd32, 1'b1, 1'b1);
    repeat (20) tick();
    chk("midpend_busy", cfg_busy, 1);
    do_reset();
    repeat (200) tick();
    chk("midpend_prescale", prescale, 8);
    chk("midpend_par_en", PAR_EN, 0);

    // Illegal prescale
    cfg_write(6'd12, 1'b1, 1'b0);
    chk("illegal_err", cfg_err, 1);
    chk("illegal_busy", cfg_busy, 0);
    tick();
    chk("illegal_err_fall", cfg_err, 0);
    chk("illegal_prescale", prescale, 8);

    // Overrun: nine pushes into an eight-deep FIFO
    out_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      rx_data_valid = 1; rx_p_data = 8'(i);
      tick();
    end
    rx_data_valid = 0;
    chk("ovr_count", fifo_count, 8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_drop", drop_cnt, DROP_ON ? 1 : 0);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovr_pop_data", out_data, i);
      tick();
    end
    out_ready = 0;
    chk("ovr_empty", out_valid, 0);
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    chk("ovr_clr_flag", overrun, 0);
    chk("ovr_clr_drop", drop_cnt, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      rx_data_valid = 1; rx_p_data = 8'h10 + 8'(i);
      tick();
    end
    rx_data_valid = 1; rx_p_data = 8'hAA; out_ready = 1;
    tick();
    rx_data_valid = 0; out_ready = 0;
    chk("fullpp_overrun", overrun, 0);
    chk("fullpp_count", fifo_count, 8);
    out_ready = 1;
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = out_data;
      tick();
    end
    out_ready = 0;
    chk("fullpp_last", last, 8'hAA);

    // Drop counter saturation and clear priority over a same-cycle drop
    rx_data_valid = 1;
    for (int i = 0; i < 8 + 260; i++) begin
      rx_p_data = 8'($urandom);
      tick();
    end
    chk("sat_drop", drop_cnt, DROP_ON ? 255 : 0);
    ovr_clr = 1;
    tick();
    ovr_clr = 0; rx_data_valid = 0;
    chk("clrprio_flag", overrun, 0);
    chk("clrprio_drop", drop_cnt, 0);
    out_ready = 1;
    repeat (8) tick();
    out_ready = 0;

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rx_data_valid = ($urandom_range(0, 9) < 3);
      rx_p_data     = 8'($urandom);
      out_ready     = ($urandom_range(0, 1) == 1);
      ovr_clr       = ($urandom_range(0, 31) == 0);
      rx_in         = ($urandom_range(0, 99) != 0);
      cfg_wr        = ($urandom_range(0, 49) == 0);
      cfg_prescale  = ptab[$urandom_range(0, 7)];
      cfg_par_en    = 1'($urandom);
      cfg_par_typ   = 1'($urandom);
      tick();
    end
    cfg_wr = 0; rx_data_valid = 0; out_ready = 0; ovr_clr = 0; rx_in = 1;
    repeat (400) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
